// File: rtl/sens_pxd_tx_pkg.sv
// Shared types for the parallel-sensor pixel transmitter: FSM encoding and pattern codes.
package sens_pxd_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FPRE,
      ST_LINE,
      ST_HBL,
      ST_VBL
   } tx_state_e;

   localparam logic [1:0] PAT_COL     = 2'd0;
   localparam logic [1:0] PAT_LINE    = 2'd1;
   localparam logic [1:0] PAT_COLLINE = 2'd2;
   localparam logic [1:0] PAT_EXT     = 2'd3;

   // delay stages ahead of the registered skew output (tap 0..3 -> 1..4 cycles total)
   localparam int unsigned SKEW_DEPTH = 3;

endpackage

// File: rtl/sens_sync_skew.sv
// Programmable 1..4 cycle delay for sync strobes; tap selects extra delay 0..3.
module sens_sync_skew
   import sens_pxd_tx_pkg::*;
#(
   parameter int unsigned W = 2
) (
   input  logic         mclk,
   input  logic         mrst,
   input  logic [W-1:0] din,
   input  logic [1:0]   tap,
   output logic [W-1:0] dout
);

   logic [W-1:0] sr [SKEW_DEPTH];

   always_ff @(posedge mclk) begin
      if (mrst) begin
         for (int i = 0; i < SKEW_DEPTH; i++) sr[i] <= '0;
         dout <= '0;
      end else begin
         sr[0] <= din;
         for (int i = 1; i < SKEW_DEPTH; i++) sr[i] <= sr[i-1];
         case (tap)
            2'd0:    dout <= din;
            2'd1:    dout <= sr[0];
            2'd2:    dout <= sr[1];
            default: dout <= sr[2];
         endcase
      end
   end

endmodule

// File: rtl/sens_pxd_tx.sv
// Pixel-bus frame generator driving pxd/hact/vact pads from a test pattern or an upstream stream.
module sens_pxd_tx
   import sens_pxd_tx_pkg::*;
#(
   parameter int unsigned PXD_WIDTH = 12,
   parameter int unsigned GEOM_BITS = 14
) (
   input  logic                 mclk,
   input  logic                 mrst,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 continuous,
   input  logic [1:0]           pattern,
   input  logic [1:0]           quadrant,
   input  logic [GEOM_BITS-1:0] width_m1,
   input  logic [GEOM_BITS-1:0] height_m1,
   input  logic [GEOM_BITS-1:0] hblank_m1,
   input  logic [GEOM_BITS-1:0] vblank_m1,
   input  logic [PXD_WIDTH-1:0] px_data,
   input  logic                 px_valid,
   output logic                 px_ready,
   output logic [PXD_WIDTH-1:0] pxd_out,
   output logic                 pxd_en,
   output logic                 hact,
   output logic                 vact,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 underrun
);

   tx_state_e            state_q, state_d;
   logic [GEOM_BITS-1:0] cnt_q, cnt_d, line_q, line_d;
   logic [GEOM_BITS-1:0] w_q, h_q, hb_q, vb_q;
   logic [1:0]           pat_q, quad_q;
   logic                 stop_pend_q;
   logic                 load_cfg_c, done_c;
   logic [PXD_WIDTH-1:0] pix_c;
   logic [1:0]           act_raw_c, act_skew;

   // next-state: cnt is the phase counter and doubles as col inside LINE
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + GEOM_BITS'(1);
      line_d     = line_q;
      load_cfg_c = 1'b0;
      done_c     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d  = '0;
            line_d = '0;
            if (start) begin
               state_d    = ST_FPRE;
               load_cfg_c = 1'b1;
            end
         end
         ST_FPRE: if (cnt_q == hb_q) begin
            state_d = ST_LINE;
            cnt_d   = '0;
         end
         ST_LINE: if (cnt_q == w_q) begin
            state_d = ST_HBL;
            cnt_d   = '0;
         end
         ST_HBL: if (cnt_q == hb_q) begin
            cnt_d = '0;
            if (line_q < h_q) begin
               state_d = ST_LINE;
               line_d  = line_q + GEOM_BITS'(1);
            end else begin
               state_d = ST_VBL;
               line_d  = '0;
            end
         end
         ST_VBL: if (cnt_q == vb_q) begin
            cnt_d  = '0;
            done_c = 1'b1;
            if (continuous && !stop_pend_q) begin
               state_d    = ST_FPRE;
               load_cfg_c = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge mclk) begin
      if (mrst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         line_q      <= '0;
         w_q         <= '0;
         h_q         <= '0;
         hb_q        <= '0;
         vb_q        <= '0;
         pat_q       <= PAT_COL;
         quad_q      <= '0;
         stop_pend_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
         if (load_cfg_c) begin
            w_q    <= width_m1;
            h_q    <= height_m1;
            hb_q   <= hblank_m1;
            vb_q   <= vblank_m1;
            pat_q  <= pattern;
            quad_q <= quadrant;
         end
         if (state_d == ST_IDLE) stop_pend_q <= 1'b0;
         else if (stop)          stop_pend_q <= 1'b1;
      end
   end

   // pixel source; pattern values wrap at the bus width
   always_comb begin
      pix_c = '0;
      case (pat_q)
         PAT_COL:     pix_c = PXD_WIDTH'(cnt_q);
         PAT_LINE:    pix_c = PXD_WIDTH'(line_q);
         PAT_COLLINE: pix_c = PXD_WIDTH'(cnt_q + line_q);
         default:     if (px_valid && px_ready) pix_c = px_data;
      endcase
   end

   always_ff @(posedge mclk) begin
      if (mrst) begin
         pxd_out    <= '0;
         pxd_en     <= 1'b0;
         busy       <= 1'b0;
         px_ready   <= 1'b0;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         pxd_out    <= (state_q == ST_LINE) ? pix_c : '0;
         busy       <= (state_d != ST_IDLE);
         pxd_en     <= busy;
         px_ready   <= (state_d == ST_LINE) && (pat_q == PAT_EXT);
         frame_done <= done_c;
         if (state_q == ST_IDLE && start)
            underrun <= 1'b0;
         else if (state_q == ST_LINE && pat_q == PAT_EXT && !px_valid)
            underrun <= 1'b1;
      end
   end

   assign act_raw_c = {state_q == ST_LINE,
                       state_q == ST_FPRE || state_q == ST_LINE || state_q == ST_HBL};

   sens_sync_skew #(.W(2)) u_skew (
      .mclk (mclk),
      .mrst (mrst),
      .din  (act_raw_c),
      .tap  (quad_q),
      .dout (act_skew)
   );

   assign hact = act_skew[1];
   assign vact = act_skew[0];

endmodule

// File: tb/tb_sens_pxd_tx.sv
// Randomized self-checking bench for sens_pxd_tx against a frame-list reference model.
module tb_sens_pxd_tx;

   localparam int unsigned PXD_WIDTH = 12;
   localparam int unsigned GEOM_BITS = 14;

   logic                 mclk = 1'b0;
   logic                 mrst = 1'b1;
   logic                 start = 1'b0, stop = 1'b0, continuous = 1'b0;
   logic [1:0]           pattern = '0, quadrant = '0;
   logic [GEOM_BITS-1:0] width_m1 = '0, height_m1 = '0, hblank_m1 = '0, vblank_m1 = '0;
   logic [PXD_WIDTH-1:0] px_data = '0;
   logic                 px_valid = 1'b0;
   logic                 px_ready, pxd_en, hact, vact, busy, frame_done, underrun;
   logic [PXD_WIDTH-1:0] pxd_out;

   always #5 mclk = ~mclk;

   sens_pxd_tx #(.PXD_WIDTH(PXD_WIDTH), .GEOM_BITS(GEOM_BITS)) dut (
      .mclk(mclk), .mrst(mrst), .start(start), .stop(stop), .continuous(continuous),
      .pattern(pattern), .quadrant(quadrant), .width_m1(width_m1), .height_m1(height_m1),
      .hblank_m1(hblank_m1), .vblank_m1(vblank_m1), .px_data(px_data), .px_valid(px_valid),
      .px_ready(px_ready), .pxd_out(pxd_out), .pxd_en(pxd_en), .hact(hact), .vact(vact),
      .busy(busy), .frame_done(frame_done), .underrun(underrun)
   );

   // one entry per frame cycle as seen on the un-delayed timeline
   typedef struct {
      bit v;
      bit h;
      int col;
      int line;
      bit last;
   } rec_t;

   rec_t fq[$];
   rec_t cur;
   bit   m_idle = 1'b1, m_pend = 1'b0, m_und = 1'b0;
   int   c_w, c_h, c_hb, c_vb, c_pat = 0, c_q = 0;
   int   m_frames = 0;
   bit   hist_h[8], hist_v[8];
   int   cyc = 8;

   logic [PXD_WIDTH-1:0] e_pxd = '0;
   bit   e_en, e_h, e_v, e_busy, e_fd, e_und, e_rdy;

   int   n_cmp = 0, n_bad = 0;
   int   fd_seen = 0, vact_cycles = 0, rdy_cycles = 0;
   bit   rnd_valid = 1'b0, noise = 1'b0;
   int   drop_line = -1, drop_col = -1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic rec_t mk(bit v, bit h, int col, int line, bit last);
      rec_t r;
      r.v = v; r.h = h; r.col = col; r.line = line; r.last = last;
      return r;
   endfunction

   // latch config from the inputs and lay out the whole frame
   function automatic void build_frame();
      c_w   = int'(width_m1);  c_h   = int'(height_m1);
      c_hb  = int'(hblank_m1); c_vb  = int'(vblank_m1);
      c_pat = int'(pattern);   c_q   = int'(quadrant);
      m_frames++;
      fq.delete();
      for (int i = 0; i <= c_hb; i++) fq.push_back(mk(1, 0, 0, 0, 0));
      for (int l = 0; l <= c_h; l++) begin
         for (int c = 0; c <= c_w; c++) fq.push_back(mk(1, 1, c, l, 0));
         for (int i = 0; i <= c_hb; i++) fq.push_back(mk(1, 0, 0, 0, 0));
      end
      for (int i = 0; i <= c_vb; i++) fq.push_back(mk(0, 0, 0, 0, i == c_vb));
      cur = fq.pop_front();
   endfunction

   task automatic step();
      bit         raw_h, raw_v;
      int         q_now;
      logic [2:0] wi, ri;
      px_data = PXD_WIDTH'($urandom);
      if (rnd_valid) px_valid = ($urandom_range(0, 4) != 0);
      else px_valid = !(!m_idle && cur.h && cur.line == drop_line && cur.col == drop_col);
      q_now = c_q;
      raw_h = 1'b0; raw_v = 1'b0;
      e_pxd = '0; e_en = 1'b0; e_fd = 1'b0;
      if (mrst) begin
         m_idle = 1'b1; m_pend = 1'b0; m_und = 1'b0;
         c_q = 0; c_pat = 0;
         fq.delete();
         for (int i = 0; i < 8; i++) begin hist_h[i] = 1'b0; hist_v[i] = 1'b0; end
      end else if (m_idle) begin
         if (start) begin
            build_frame();
            m_idle = 1'b0;
            m_pend = stop;
            m_und  = 1'b0;
         end
      end else begin
         raw_h = cur.h; raw_v = cur.v;
         e_en = 1'b1; e_fd = cur.last;
         if (cur.h) begin
            case (c_pat)
               0:       e_pxd = PXD_WIDTH'(cur.col);
               1:       e_pxd = PXD_WIDTH'(cur.line);
               2:       e_pxd = PXD_WIDTH'(cur.col + cur.line);
               default: e_pxd = px_valid ? px_data : '0;
            endcase
            if (c_pat == 3 && !px_valid) m_und = 1'b1;
         end
         if (fq.size() > 0) begin
            cur = fq.pop_front();
            if (stop) m_pend = 1'b1;
         end else if (continuous && !m_pend) begin
            build_frame();
            if (stop) m_pend = 1'b1;
         end else begin
            m_idle = 1'b1;
            m_pend = 1'b0;
         end
      end
      wi = 3'(cyc);
      ri = 3'(cyc - q_now);
      hist_h[wi] = raw_h;
      hist_v[wi] = raw_v;
      e_h    = mrst ? 1'b0 : hist_h[ri];
      e_v    = mrst ? 1'b0 : hist_v[ri];
      e_busy = !m_idle;
      e_rdy  = !m_idle && cur.h && c_pat == 3;
      e_und  = m_und;
      cyc++;
      @(negedge mclk);
      chk("pxd_out",    32'(pxd_out),    32'(e_pxd));
      chk("pxd_en",     32'(pxd_en),     32'(e_en));
      chk("hact",       32'(hact),       32'(e_h));
      chk("vact",       32'(vact),       32'(e_v));
      chk("busy",       32'(busy),       32'(e_busy));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
      chk("underrun",   32'(underrun),   32'(e_und));
      chk("px_ready",   32'(px_ready),   32'(e_rdy));
      fd_seen     += int'(frame_done);
      vact_cycles += int'(vact);
      rdy_cycles  += int'(px_ready);
   endtask

   task automatic set_cfg(input int w, input int h, input int hb, input int vb,
                          input int pat, input int q);
      width_m1  = GEOM_BITS'(w);  height_m1 = GEOM_BITS'(h);
      hblank_m1 = GEOM_BITS'(hb); vblank_m1 = GEOM_BITS'(vb);
      pattern   = 2'(pat);        quadrant  = 2'(q);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic run_to_idle(input int budget);
      int k = 0;
      while (!m_idle && k < budget) begin
         if (noise) begin
            start    = ($urandom_range(0, 7) == 0);
            stop     = ($urandom_range(0, 15) == 0);
            pattern  = 2'($urandom);
            quadrant = 2'($urandom);
            width_m1 = GEOM_BITS'($urandom_range(0, 3));
         end
         step();
         k++;
      end
      start = 1'b0;
      stop  = 1'b0;
      repeat (5) step();
      chk("idle_reached", 32'(busy), 32'd0);
   endtask

   initial begin
      int k;
      @(negedge mclk);
      repeat (3) step();
      mrst = 1'b0;
      repeat (2) step();

      // geometry, column ramp, no skew
      set_cfg(3, 1, 1, 2, 0, 0);
      fd_seen = 0; vact_cycles = 0;
      pulse_start();
      run_to_idle(200);
      chk("geom_vact_len", 32'(vact_cycles), 32'd14);
      chk("geom_done_cnt", 32'(fd_seen), 32'd1);

      // col+line pattern with maximum skew
      set_cfg(3, 1, 1, 2, 2, 3);
      pulse_start();
      run_to_idle(200);

      // external stream with one missing pixel
      set_cfg(7, 1, 1, 2, 3, 0);
      drop_line = 0; drop_col = 5; rdy_cycles = 0;
      pulse_start();
      run_to_idle(200);
      chk("ext_ready_cnt", 32'(rdy_cycles), 32'd16);
      chk("ext_underrun", 32'(underrun), 32'd1);
      drop_line = -1; drop_col = -1;
      pulse_start();
      chk("ext_underrun_clr", 32'(underrun), 32'd0);
      run_to_idle(200);

      // continuous mode, stop during frame 2, stray start ignored
      continuous = 1'b1;
      set_cfg(2, 1, 1, 1, 1, 1);
      fd_seen = 0;
      k = m_frames;
      pulse_start();
      for (int i = 0; i < 300 && m_frames < k + 2; i++) step();
      repeat (3) step();
      pulse_start();
      stop = 1'b1;
      step();
      stop = 1'b0;
      run_to_idle(300);
      chk("cont_done_cnt", 32'(fd_seen), 32'd2);

      // start with stop while idle: a single frame even in continuous mode
      fd_seen = 0;
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      run_to_idle(300);
      chk("startstop_single", 32'(fd_seen), 32'd1);
      continuous = 1'b0;

      // reset during line 1, then a clean frame
      set_cfg(3, 2, 1, 1, 0, 2);
      fd_seen = 0;
      pulse_start();
      for (int i = 0; i < 200 && !(!m_idle && cur.h && cur.line == 1); i++) step();
      mrst = 1'b1;
      step();
      mrst = 1'b0;
      repeat (4) step();
      chk("rst_no_done", 32'(fd_seen), 32'd0);
      pulse_start();
      run_to_idle(200);
      chk("rst_clean_done", 32'(fd_seen), 32'd1);

      // minimum geometry
      set_cfg(0, 0, 0, 0, 1, 0);
      fd_seen = 0; vact_cycles = 0;
      pulse_start();
      run_to_idle(50);
      chk("min_vact_len", 32'(vact_cycles), 32'd3);
      chk("min_done_cnt", 32'(fd_seen), 32'd1);

      // random frames with input noise while busy
      rnd_valid = 1'b1;
      for (int f = 0; f < 6; f++) begin
         set_cfg($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 2),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         pulse_start();
         noise = 1'b1;
         run_to_idle(600);
         noise = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
